// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encodings, frame sizes and mid-bit sample points
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'b000,
        START_BIT  = 3'b001,
        DATA_BIT   = 3'b010,
        PARITY_BIT = 3'b011,
        STOP_BIT   = 3'b100
    } uart_state_t;

    localparam int DATA_BITS    = 8;
    localparam int OVERSAMPLE   = 16;
    localparam int START_SAMPLE = OVERSAMPLE / 2 - 1;
    localparam int BIT_SAMPLE   = OVERSAMPLE - 1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for the serial line, resets to idle-high
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // shift the raw line through two flops; reset to the idle level
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled 8-bit + parity + stop UART receiver; RX_MAJORITY_EN enables 2-of-3 bit voting
module uart_rx #(
    parameter int PARITY_ODD = 0,
    parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       parity_err,
    output logic       frame_err
);

    import uart_pkg::*;

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] START_PT = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] BIT_PT   = CW'(OVERSAMPLE - 1);

    uart_state_t    state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [BW-1:0]  bcnt, bcnt_n;
    logic [7:0]     shift, shift_n;
    logic           pe, pe_n;
    logic [7:0]     data_n;
    logic           valid_n, perr_n, ferr_n;
    logic           rxs, bit_s;

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_in),
        .q   (rxs)
    );

`ifdef RX_MAJORITY_EN
    logic [1:0]    maj;
    logic [CW-1:0] pt;
    assign pt    = (state == START_BIT) ? START_PT : BIT_PT;
    assign bit_s = maj3(maj[1], maj[0], rxs);

    // capture the two samples preceding the decision tick for voting
    always_ff @(posedge clk) begin
        if (rst)
            maj <= 2'b11;
        else if (baud_tick && (cnt == pt - CW'(2) || cnt == pt - CW'(1)))
            maj <= {maj[0], rxs};
    end
`else
    assign bit_s = rxs;
`endif

    assign rx_busy = (state != IDLE);

    // frame sequencing: everything advances only on baud_tick
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bcnt_n  = bcnt;
        shift_n = shift;
        pe_n    = pe;
        data_n  = rx_data;
        perr_n  = parity_err;
        ferr_n  = frame_err;
        valid_n = 1'b0;
        if (baud_tick) begin
            cnt_n = cnt + 1'b1;
            case (state)
                IDLE: begin
                    cnt_n = '0;
                    if (!rxs)
                        state_n = START_BIT;
                end
                START_BIT: if (cnt == START_PT) begin
                    cnt_n   = '0;
                    bcnt_n  = '0;
                    state_n = bit_s ? IDLE : DATA_BIT;
                end
                DATA_BIT: if (cnt == BIT_PT) begin
                    shift_n = {bit_s, shift[7:1]};
                    bcnt_n  = bcnt + 1'b1;
                    if (bcnt == BW'(DATA_BITS - 1))
                        state_n = PARITY_BIT;
                end
                PARITY_BIT: if (cnt == BIT_PT) begin
                    pe_n    = ^shift ^ bit_s ^ 1'(PARITY_ODD);
                    state_n = STOP_BIT;
                end
                STOP_BIT: if (cnt == BIT_PT) begin
                    data_n  = shift;
                    perr_n  = pe;
                    ferr_n  = ~bit_s;
                    valid_n = 1'b1;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // state, counters and held outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bcnt       <= '0;
            shift      <= '0;
            pe         <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bcnt       <= bcnt_n;
            shift      <= shift_n;
            pe         <= pe_n;
            rx_data    <= data_n;
            rx_valid   <= valid_n;
            parity_err <= perr_n;
            frame_err  <= ferr_n;
        end
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receive stage that consumes the serial stream produced by the transmit side: start bit, 8 data bits LSB-first, one parity bit, one stop bit.
- Oversamples the line at 16x using the shared baud tick and validates the start bit at mid-bit.
- Samples every later bit at its centre and presents the assembled byte with error flags as a one-cycle valid pulse.
- Sits between the pad-side line and the host-side receive buffer.

Parameters:
PARITY_ODD, 0, 0 = even parity expected, 1 = odd parity expected.
OVERSAMPLE, 16, baud_tick pulses per bit; must be a power of two, at least 8.

Ports:
clk  input  1  system clock.
rst  input  1  reset; synchronous to clk, active-high.
baud_tick  input  1  one-clk enable at 16x baud rate.
rx_in  input  1  asynchronous serial line, idle high.
rx_data  output  8  last received byte; holds until the next frame completes.
rx_valid  output  1  one-clk pulse when a frame completes.
rx_busy  output  1  high in any state other than IDLE.
parity_err  output  1  parity mismatch for the frame flagged by rx_valid; holds.
frame_err  output  1  stop bit sampled low for that frame; holds.

Behaviour:
- Reset: state=IDLE, tick counter=0, bit counter=0, shift register=0x00. All outputs 0 (rx_data=0x00).
- Reset mid-frame: abort to IDLE on the next clk edge; no rx_valid is produced.
- rx_in passes through a 2-flop synchronizer (2 clk latency). All decisions use the synchronized value rxs.
- The tick counter is 4 bits, advances only on baud_tick, and wraps 15 -> 0.
- With baud_tick low, the FSM and all counters hold.
- State encoding: IDLE=3'b000, START_BIT=3'b001, DATA_BIT=3'b010, PARITY_BIT=3'b011, STOP_BIT=3'b100. Any other code returns to IDLE.
- IDLE: rxs==0 -> START_BIT, tick counter cleared to 0.
- START_BIT: at baud_tick with counter==7, the sample is taken.
  - Sample 0 -> DATA_BIT, counter cleared, bit counter cleared.
  - Sample 1 -> IDLE (glitch rejected).
- DATA_BIT: at baud_tick with counter==15 (bit centre), shift the sample into the MSB of the shift register, shifting right (LSB-first).
  - The bit counter counts 0..7.
  - After the 8th sample -> PARITY_BIT.
- PARITY_BIT: at counter==15, sample p.
  - parity_err_next = (^shift ^ p ^ PARITY_ODD).
  - -> STOP_BIT.
- STOP_BIT: at counter==15, sample s.
  - On the next clk edge: rx_data<=shift, parity_err<=parity_err_next, frame_err<=~s, rx_valid<=1 for one clk.
  - State -> IDLE.
  - rx_valid is asserted even when there is an error.
- A new start edge is accepted from IDLE in the clk immediately after the STOP_BIT sample, so back-to-back frames carry no dead time.
- If the stop bit is 0 and the line stays low, IDLE sees rxs==0 and begins a new START_BIT validation. This is required behaviour (break handling is out of scope).
- rx_busy = (state != IDLE), combinational from the state register.
- Total latency: rx_valid occurs 2 clk + 1 clk after the baud_tick that samples the stop-bit centre on the raw line.

Optional Feature:
Macro RX_MAJORITY_EN.
- Defined: each bit value is the 2-of-3 majority of rxs captured on baud_ticks at counter 13, 14 and 15 (start bit: counter 5, 6, 7). The decision is made at the same tick as the single-sample case, so timing and latency are unchanged.
- Undefined: a single rxs sample at counter 15 (start bit: counter 7). No extra sample flops are synthesized.

Decomposition:
- Shared package uart_pkg holds:
  - state encodings IDLE..STOP_BIT, shared with the TX FSM;
  - DATA_BITS=8 and OVERSAMPLE=16;
  - mid-bit constants START_SAMPLE=7 and BIT_SAMPLE=15.
- One sub-module: uart_sync2, a 2-flop synchronizer with a reset value of 1 (line idle).

Test Plan:
- 0xA5, parity 0, stop 1, at 16 ticks/bit -> one rx_valid pulse, rx_data=0xA5, parity_err=0, frame_err=0, rx_busy low after the pulse.
- 0x3C with parity bit 1 (even mode) -> rx_data=0x3C, parity_err=1, frame_err=0. Repeat with PARITY_ODD=1 -> parity_err=0.
- 0x81, parity 0, stop bit driven 0 -> rx_valid pulses, rx_data=0x81, frame_err=1. The next clean frame 0x55 clears frame_err to 0.
- rx_in low for only 4 baud ticks, then high -> no rx_valid, rx_busy returns to 0 at the counter==7 tick.
  - With RX_MAJORITY_EN, a 1-tick high glitch at counter 14 of data bit 3 for 0x00 -> rx_data=0x00.
- Back-to-back 0x00 then 0xFF with no idle gap -> two rx_valid pulses, data 0x00 then 0xFF, no errors.
- rst asserted for 1 clk during DATA_BIT bit 4 -> no rx_valid. All outputs 0 on the next clk. The next full frame 0x12 is received correctly.
